// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - PC generation, imem request/response tracking and an instruction buffer feeding ID.
// Optional macro FETCH_MISALIGN_CHK_EN: a misaligned redirect target sets a sticky error and halts fetch
// until the next aligned redirect; without it the low target bits are silently cleared.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_instr,
    output logic [6:0]  o_id_opcode,
    output logic [2:0]  o_id_func3,
    output logic [6:0]  o_id_func7,
    output logic        o_misalign_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_pq_wr;
    logic [AW-1:0] r_pq_rd;
    logic [31:0]   r_buf_pc    [FIFO_DEPTH];
    logic [31:0]   r_buf_instr [FIFO_DEPTH];
    logic [31:0]   r_pcq       [FIFO_DEPTH];

    logic w_halted;
    logic w_req_fire;
    logic w_id_fire;
    logic w_credit_ok;
    logic w_buf_wr;
    logic w_rsp_drop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_halt_err;
    // Sticky misalign flag, updated by every redirect; it also halts fetch while set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_halt_err <= 1'b0;
        else if (i_redirect_valid)
            r_halt_err <= |i_redirect_pc[1:0];
    end
    assign w_halted       = r_halt_err;
    assign o_misalign_err = r_halt_err;
`else
    assign w_halted       = 1'b0;
    assign o_misalign_err = 1'b0;
`endif

    // Buffered words plus in-flight requests (including ones to be dropped) never exceed the buffer depth
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < (DEPTH_W + (CW+1)'(w_id_fire));
    assign o_imem_req_valid = rst_n & !i_redirect_valid & !w_halted & w_credit_ok;
    assign o_imem_req_addr  = r_fetch_pc;
    assign w_req_fire = o_imem_req_valid & i_imem_req_ready;
    assign o_id_valid = (r_count != '0) & !i_redirect_valid;
    assign w_id_fire  = o_id_valid & i_id_ready;
    assign w_rsp_drop = i_imem_rsp_valid & (r_drop_cnt != '0);
    assign w_buf_wr   = i_imem_rsp_valid & (r_drop_cnt == '0) & !i_redirect_valid;

    assign o_id_pc     = r_buf_pc[r_head];
    assign o_id_instr  = r_buf_instr[r_head];
    assign o_id_opcode = o_id_instr[6:0];
    assign o_id_func3  = o_id_instr[14:12];
    assign o_id_func7  = o_id_instr[31:25];

    // Fetch PC: redirect target (word aligned) wins, otherwise advance on each accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fetch_pc <= RESET_PC;
        else if (i_redirect_valid)
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
        else if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + 32'd4;
    end

    // Outstanding request count and the number of wrong-path responses still to be discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
            r_drop_cnt <= i_redirect_valid ? r_inflight - CW'(i_imem_rsp_valid)
                                           : r_drop_cnt - CW'(w_rsp_drop);
        end
    end

    // Per-request PC queue: pushed on accept, popped on every response so PCs stay paired in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_pcq[i] <= '0;
            r_pq_wr <= '0;
            r_pq_rd <= '0;
        end else begin
            if (w_req_fire) begin
                r_pcq[r_pq_wr] <= r_fetch_pc;
                r_pq_wr <= f_inc(r_pq_wr);
            end
            if (i_imem_rsp_valid)
                r_pq_rd <= f_inc(r_pq_rd);
        end
    end

    // Circular instruction buffer; a redirect flushes it and suppresses any same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_buf_wr) begin
                r_buf_pc[r_tail]    <= r_pcq[r_pq_rd];
                r_buf_instr[r_tail] <= i_imem_rsp_data;
                r_tail <= f_inc(r_tail);
            end
            if (w_id_fire)
                r_head <= f_inc(r_head);
            r_count <= r_count + CW'(w_buf_wr) - CW'(w_id_fire);
        end
    end
endmodule
